// File: rtl/ibus_responder.sv
// Instruction-fetch responder: accepts one fetch, reads an aligned 64-bit word from memory, returns 32 bits.
// Optional single-line fetch buffer is enabled with `define IBUS_LINE_BUF_EN.
//
// state | meaning
// IDLE  | waiting for a fetch request
// MEM   | memory read outstanding, watchdog running
// RESP  | returning the instruction word (data_ok pulse)
module ibus_responder #(
   parameter int MEM_LAT_MAX = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ireq_valid,
   input  logic [63:0] ireq_addr,
   output logic        iresp_addr_ok,
   output logic        iresp_data_ok,
   output logic [31:0] iresp_data,
   input  logic        flush,
   output logic        mreq_valid,
   output logic [63:0] mreq_addr,
   input  logic        mresp_valid,
   input  logic [63:0] mresp_data,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

   localparam int WD_W = (MEM_LAT_MAX < 2) ? 1 : $clog2(MEM_LAT_MAX + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_LAT_MAX > 0) ? MEM_LAT_MAX - 1 : 0);
   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t            state_q, state_d;
   logic [63:2]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   logic              addr_ok_c, data_ok_c, mreq_valid_c;
   logic              buf_hit;
   logic [31:0]       buf_word;
   logic              unused_addr;

   assign unused_addr = ^ireq_addr[1:0];

`ifdef IBUS_LINE_BUF_EN
   logic [63:0] buf_data_q;
   logic [63:3] buf_tag_q;
   logic        buf_vld_q;
   logic        buf_fill;

   // A request coincident with flush must miss, even against a matching tag.
   assign buf_fill = (state_q == MEM) && mresp_valid;
   assign buf_hit  = buf_vld_q && !flush && (buf_tag_q == ireq_addr[63:3]);
   assign buf_word = ireq_addr[2] ? buf_data_q[63:32] : buf_data_q[31:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_vld_q  <= 1'b0;
         buf_tag_q  <= '0;
         buf_data_q <= '0;
      end else if (flush) begin
         buf_vld_q <= 1'b0;
      end else if (buf_fill) begin
         buf_vld_q  <= 1'b1;
         buf_tag_q  <= addr_q[63:3];
         buf_data_q <= mresp_data;
      end
   end
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign buf_hit      = 1'b0;
   assign buf_word     = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      wd_d         = wd_q;
      err_d        = err_q;
      addr_ok_c    = 1'b0;
      data_ok_c    = 1'b0;
      mreq_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (ireq_valid) begin
               addr_ok_c = 1'b1;
               addr_d    = ireq_addr[63:2];
               wd_d      = '0;
               if (buf_hit) begin
                  data_d  = buf_word;
                  state_d = RESP;
               end else begin
                  state_d = MEM;
               end
            end
         end
         MEM: begin
            mreq_valid_c = 1'b1;
            wd_d         = wd_q + 1'b1;
            // Real data wins over a timeout landing in the same cycle.
            if (mresp_valid) begin
               data_d  = addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
               state_d = RESP;
            end else if ((MEM_LAT_MAX != 0) && (wd_q == WD_LAST)) begin
               data_d  = NOP;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            data_ok_c = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign iresp_addr_ok = addr_ok_c && !reset;
   assign iresp_data_ok = data_ok_c;
   assign iresp_data    = data_q;
   assign mreq_valid    = mreq_valid_c;
   assign mreq_addr     = {addr_q[63:3], 3'b000};
   assign err           = err_q;

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder (watchdog limit 8); line-buffer checks follow IBUS_LINE_BUF_EN.
module tb_ibus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        flush;
   logic        mreq_valid;
   logic [63:0] mreq_addr;
   logic        mresp_valid;
   logic [63:0] mresp_data;
   logic        err;

   int n_cmp = 0;
   int n_mis = 0;

   localparam logic [63:0] MEMWORD = 64'h00A0_0093_0000_0513;

   ibus_responder #(.MEM_LAT_MAX(8)) dut (
      .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .flush(flush), .mreq_valid(mreq_valid), .mreq_addr(mreq_addr),
      .mresp_valid(mresp_valid), .mresp_data(mresp_data), .err(err)
   );

   always #5 clk = ~clk;

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
      flush = 1'b0; mresp_valid = 1'b0; mresp_data = '0;
      #22;
      n_cmp++; if (iresp_addr_ok !== 1'b0) begin n_mis++; $display("FAIL rst_addr_ok: got %b want 0", iresp_addr_ok); end
      n_cmp++; if (iresp_data_ok !== 1'b0) begin n_mis++; $display("FAIL rst_data_ok: got %b want 0", iresp_data_ok); end
      n_cmp++; if (iresp_data !== 32'h0) begin n_mis++; $display("FAIL rst_data: got %h want 0", iresp_data); end
      n_cmp++; if (mreq_valid !== 1'b0) begin n_mis++; $display("FAIL rst_mreq_valid: got %b want 0", mreq_valid); end
      n_cmp++; if (mreq_addr !== 64'h0) begin n_mis++; $display("FAIL rst_mreq_addr: got %h want 0", mreq_addr); end
      n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b want 0", err); end
      ireq_valid = 1'b0;
      next_cyc();
      reset = 1'b0;
      next_cyc();
   endtask

   task automatic test_miss();
      next_cyc(); ireq_valid = 1'b1; ireq_addr = 64'h8000_0004; smp();
      n_cmp++; if (iresp_addr_ok !== 1'b1) begin n_mis++; $display("FAIL miss_addr_ok: got %b want 1", iresp_addr_ok); end
      for (int c = 1; c <= 3; c++) begin
         next_cyc();
         if (c == 3) begin mresp_valid = 1'b1; mresp_data = MEMWORD; end
         smp();
         n_cmp++; if (mreq_valid !== 1'b1) begin n_mis++; $display("FAIL miss_mreq_valid c%0d: got %b want 1", c, mreq_valid); end
         n_cmp++; if (mreq_addr !== 64'h8000_0000) begin n_mis++; $display("FAIL miss_mreq_addr c%0d: got %h want 80000000", c, mreq_addr); end
         n_cmp++; if (iresp_addr_ok !== 1'b0 || iresp_data_ok !== 1'b0) begin n_mis++; $display("FAIL miss_ok_quiet c%0d: got %b%b want 00", c, iresp_addr_ok, iresp_data_ok); end
      end
      next_cyc(); mresp_valid = 1'b0; smp();
      n_cmp++; if (iresp_data_ok !== 1'b1) begin n_mis++; $display("FAIL miss_data_ok: got %b want 1", iresp_data_ok); end
      n_cmp++; if (iresp_data !== 32'h00A0_0093) begin n_mis++; $display("FAIL miss_data: got %h want 00a00093", iresp_data); end
      n_cmp++; if (mreq_valid !== 1'b0) begin n_mis++; $display("FAIL miss_mreq_drop: got %b want 0", mreq_valid); end
      next_cyc(); ireq_valid = 1'b0; smp();
      n_cmp++; if (iresp_data_ok !== 1'b0) begin n_mis++; $display("FAIL miss_data_ok_pulse: got %b want 0", iresp_data_ok); end
      n_cmp++; if (iresp_data !== 32'h00A0_0093) begin n_mis++; $display("FAIL miss_data_hold: got %h want 00a00093", iresp_data); end
   endtask

   task automatic test_hit();
      next_cyc(); ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; smp();
      n_cmp++; if (iresp_addr_ok !== 1'b1) begin n_mis++; $display("FAIL hit_addr_ok: got %b want 1", iresp_addr_ok); end
`ifdef IBUS_LINE_BUF_EN
      n_cmp++; if (mreq_valid !== 1'b0) begin n_mis++; $display("FAIL hit_mreq_c0: got %b want 0", mreq_valid); end
      next_cyc(); smp();
      n_cmp++; if (mreq_valid !== 1'b0) begin n_mis++; $display("FAIL hit_mreq_c1: got %b want 0", mreq_valid); end
      n_cmp++; if (iresp_data_ok !== 1'b1) begin n_mis++; $display("FAIL hit_data_ok: got %b want 1", iresp_data_ok); end
      n_cmp++; if (iresp_data !== 32'h0000_0513) begin n_mis++; $display("FAIL hit_data: got %h want 00000513", iresp_data); end
`else
      next_cyc(); mresp_valid = 1'b1; mresp_data = MEMWORD; smp();
      n_cmp++; if (mreq_valid !== 1'b1) begin n_mis++; $display("FAIL nobuf_mreq: got %b want 1", mreq_valid); end
      n_cmp++; if (iresp_data_ok !== 1'b0) begin n_mis++; $display("FAIL nobuf_early_ok: got %b want 0", iresp_data_ok); end
      next_cyc(); mresp_valid = 1'b0; smp();
      n_cmp++; if (iresp_data_ok !== 1'b1) begin n_mis++; $display("FAIL nobuf_data_ok: got %b want 1", iresp_data_ok); end
      n_cmp++; if (iresp_data !== 32'h0000_0513) begin n_mis++; $display("FAIL nobuf_data: got %h want 00000513", iresp_data); end
`endif
      next_cyc(); ireq_valid = 1'b0; smp();
   endtask

   task automatic test_flush();
      // standalone flush, then a request that would otherwise hit
      next_cyc(); flush = 1'b1; smp();
      next_cyc(); flush = 1'b0; ireq_valid = 1'b1; ireq_addr = 64'h8000_0004; smp();
      next_cyc(); mresp_valid = 1'b1; mresp_data = MEMWORD; smp();
      n_cmp++; if (mreq_valid !== 1'b1) begin n_mis++; $display("FAIL flush_miss_mreq: got %b want 1", mreq_valid); end
      // flush coincident with the fill: data still returned, line left invalid
      flush = 1'b1;
      next_cyc(); mresp_valid = 1'b0; flush = 1'b0; smp();
      n_cmp++; if (iresp_data_ok !== 1'b1 || iresp_data !== 32'h00A0_0093) begin n_mis++; $display("FAIL flush_fill_resp: got %b/%h want 1/00a00093", iresp_data_ok, iresp_data); end
      next_cyc(); ireq_valid = 1'b0; smp();
      next_cyc(); ireq_valid = 1'b1; ireq_addr = 64'h8000_0000; smp();
      next_cyc(); mresp_valid = 1'b1; smp();
      n_cmp++; if (mreq_valid !== 1'b1) begin n_mis++; $display("FAIL flush_fill_wins: got %b want 1", mreq_valid); end
      next_cyc(); mresp_valid = 1'b0; smp();
      n_cmp++; if (iresp_data !== 32'h0000_0513) begin n_mis++; $display("FAIL flush_fill_data: got %h want 00000513", iresp_data); end
      next_cyc(); ireq_valid = 1'b0; smp();
      // flush coincident with the request itself forces a miss on a valid line
      next_cyc(); ireq_valid = 1'b1; ireq_addr = 64'h8000_0004; flush = 1'b1; smp();
      next_cyc(); flush = 1'b0; mresp_valid = 1'b1; smp();
      n_cmp++; if (mreq_valid !== 1'b1) begin n_mis++; $display("FAIL flush_req_miss: got %b want 1", mreq_valid); end
      next_cyc(); mresp_valid = 1'b0; smp();
      n_cmp++; if (iresp_data !== 32'h00A0_0093) begin n_mis++; $display("FAIL flush_req_data: got %h want 00a00093", iresp_data); end
      next_cyc(); ireq_valid = 1'b0; smp();
   endtask

   task automatic test_reset_mid_mem();
      next_cyc(); ireq_valid = 1'b1; ireq_addr = 64'h8000_0008; smp();
      next_cyc(); smp();
      next_cyc(); reset = 1'b1; ireq_valid = 1'b0; smp();
      n_cmp++; if (mreq_valid !== 1'b0) begin n_mis++; $display("FAIL rmid_mreq_async: got %b want 0", mreq_valid); end
      next_cyc(); reset = 1'b0; mresp_valid = 1'b1; mresp_data = 64'hDEAD_BEEF_CAFE_F00D; smp();
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (iresp_data_ok !== 1'b0 || mreq_valid !== 1'b0) begin n_mis++; $display("FAIL rmid_quiet c%0d: got ok=%b mreq=%b want 0/0", c, iresp_data_ok, mreq_valid); end
         next_cyc(); mresp_valid = 1'b0; smp();
      end
      n_cmp++; if (iresp_data !== 32'h0) begin n_mis++; $display("FAIL rmid_data: got %h want 0", iresp_data); end
   endtask

   task automatic test_addr_change();
      next_cyc(); ireq_valid = 1'b1; ireq_addr = 64'h8000_0004; smp();
      next_cyc(); ireq_addr = 64'h8000_0010; smp();
      n_cmp++; if (mreq_addr !== 64'h8000_0000) begin n_mis++; $display("FAIL achg_mreq_addr c1: got %h want 80000000", mreq_addr); end
      next_cyc(); mresp_valid = 1'b1; mresp_data = MEMWORD; smp();
      n_cmp++; if (mreq_addr !== 64'h8000_0000) begin n_mis++; $display("FAIL achg_mreq_addr c2: got %h want 80000000", mreq_addr); end
      next_cyc(); mresp_valid = 1'b0; smp();
      n_cmp++; if (iresp_data_ok !== 1'b1 || iresp_data !== 32'h00A0_0093) begin n_mis++; $display("FAIL achg_resp: got %b/%h want 1/00a00093", iresp_data_ok, iresp_data); end
      next_cyc(); ireq_valid = 1'b0; smp();
   endtask

   task automatic test_timeout();
      next_cyc(); ireq_valid = 1'b1; ireq_addr = 64'h8000_0020; smp();
      for (int c = 1; c <= 8; c++) begin
         next_cyc(); smp();
         n_cmp++; if (mreq_valid !== 1'b1 || err !== 1'b0 || iresp_data_ok !== 1'b0) begin n_mis++; $display("FAIL tmo_wait c%0d: got mreq=%b err=%b ok=%b want 1/0/0", c, mreq_valid, err, iresp_data_ok); end
      end
      next_cyc(); smp();
      n_cmp++; if (iresp_data_ok !== 1'b1) begin n_mis++; $display("FAIL tmo_data_ok: got %b want 1", iresp_data_ok); end
      n_cmp++; if (iresp_data !== 32'h0000_0013) begin n_mis++; $display("FAIL tmo_data: got %h want 00000013", iresp_data); end
      n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL tmo_err: got %b want 1", err); end
      n_cmp++; if (mreq_valid !== 1'b0) begin n_mis++; $display("FAIL tmo_mreq_drop: got %b want 0", mreq_valid); end
      next_cyc(); ireq_valid = 1'b0; smp();
      n_cmp++; if (err !== 1'b1 || iresp_data_ok !== 1'b0) begin n_mis++; $display("FAIL tmo_sticky: got err=%b ok=%b want 1/0", err, iresp_data_ok); end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_hit();
      test_flush();
      test_reset_mid_mem();
      test_addr_change();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ibus_responder.md
IBUS_RESPONDER -- requirements
Module: ibus_responder

Interface
REQ-001 SHALL have parameter MEM_LAT_MAX, default 255: watchdog limit in cycles for a memory read; 0 disables the watchdog.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ireq_valid  in  1  instruction fetch request valid, held by requester until data_ok.
REQ-005 SHALL have port ireq_addr  in  64  instruction physical address.
REQ-006 SHALL have port iresp_addr_ok  out  1  request accepted (1-cycle pulse).
REQ-007 SHALL have port iresp_data_ok  out  1  iresp_data valid (1-cycle pulse).
REQ-008 SHALL have port iresp_data  out  32  returned instruction word.
REQ-009 SHALL have port flush  in  1  invalidate line buffer (fence.i / satp write).
REQ-010 SHALL have port mreq_valid  out  1  memory read request, held until mresp_valid.
REQ-011 SHALL have port mreq_addr  out  64  8-byte-aligned memory read address.
REQ-012 SHALL have port mresp_valid  in  1  memory read data valid (1-cycle pulse).
REQ-013 SHALL have port mresp_data  in  64  memory read data.
REQ-014 SHALL have port err  out  1  sticky watchdog timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, MEM, RESP.
REQ-016 IDLE: on ireq_valid SHALL latch ireq_addr, pulse iresp_addr_ok that cycle, go to MEM (or RESP on buffer hit, REQ-028).
REQ-017 MEM: SHALL drive mreq_valid=1, mreq_addr={latched_addr[63:3],3'b000}; address SHALL NOT change while in MEM.
REQ-018 MEM: on mresp_valid SHALL capture mresp_data, go to RESP; minimum miss latency from acceptance to data_ok = memory latency + 1 cycle.
REQ-019 RESP: SHALL pulse iresp_data_ok=1 for exactly one cycle with iresp_data = latched_addr[2] ? data[63:32] : data[31:0], then return to IDLE.
REQ-020 latched_addr[1:0] SHALL be ignored; misalignment is the requester's concern.
REQ-021 Accepted transaction SHALL complete even if ireq_valid or ireq_addr changes afterwards; ireq_addr changes after acceptance SHALL be ignored.
REQ-022 New request SHALL NOT be accepted in MEM or RESP; iresp_addr_ok=0 there.
REQ-023 Watchdog: counter SHALL reset on entry to MEM, increment each MEM cycle; reaching MEM_LAT_MAX SHALL set err=1, return iresp_data=32'h00000013 (NOP) via RESP, drop mreq_valid.
REQ-024 mresp_valid outside MEM SHALL be ignored.
REQ-025 iresp_data SHALL hold its last value outside RESP.

Reset
REQ-026 While reset=1, asynchronously: state=IDLE, iresp_addr_ok=0, iresp_data_ok=0, iresp_data=0, mreq_valid=0, mreq_addr=0, err=0, watchdog=0, line buffer invalid.
REQ-027 Reset asserted mid-MEM SHALL abandon the memory read; no data_ok after reset release until a new request.

Configuration
REQ-028 With IBUS_LINE_BUF_EN defined: one 64-bit line buffer (tag addr[63:3], valid) SHALL be filled on every MEM completion; IDLE request hitting a valid matching tag SHALL skip MEM and reach RESP next cycle (hit latency 1, no mreq_valid).
REQ-029 flush SHALL clear buffer valid; flush in the same cycle as a fill SHALL win (buffer left invalid, data_ok still returned); flush coincident with an IDLE request SHALL force a miss.
REQ-030 Without IBUS_LINE_BUF_EN: no buffer, every request goes through MEM, flush ignored.

Verification
REQ-031 Miss: ireq addr 0x80000004, memory returns 0x00A0_0093_0000_0513 after 3 cycles -> addr_ok at cycle 0, mreq_addr 0x80000000, data_ok at cycle 4, iresp_data 0x00A00093.
REQ-032 Hit (IBUS_LINE_BUF_EN): after REQ-031, request 0x80000000 -> no mreq_valid, data_ok next cycle, data 0x00000513.
REQ-033 Flush: after REQ-031, flush=1 then request 0x80000004 -> mreq_valid asserted, miss path taken.
REQ-034 Reset mid-MEM: reset pulsed at MEM cycle 2, late mresp_valid -> no data_ok, state IDLE, mreq_valid=0.
REQ-035 Timeout: MEM_LAT_MAX=8, memory never responds -> err=1 after 8 MEM cycles, data_ok with 0x00000013, mreq_valid dropped.
REQ-036 Address change: ireq_addr switched to 0x80000010 during MEM -> mreq_addr stays 0x80000000, response from original address.
